fpu_req_arbiter: RTL and testbench
==================================

FPU_REQ_ARBITER -- requirements
Module: fpu_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, maximum WAIT cycles before abort (8-bit counter, legal 1..255).
REQ-002 clk  in  1  single system clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  out  1  arbiter accepts requester 0/1 this cycle.
REQ-006 req0_op / req1_op  in  3  FPU opcode.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  64  operands.
REQ-008 fpu_start  out  1  one-cycle start pulse to FPU core.
REQ-009 fpu_op  out  3;  fpu_opa, fpu_opb  out  64  latched opcode and operands to core.
REQ-010 fpu_done  in  1  core result valid pulse.
REQ-011 fpu_result  in  64;  fpu_exc  in  5  core result and exception flags.
REQ-012 rsp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-013 rsp_id  out  1  requester owning the response.
REQ-014 rsp_data  out  64;  rsp_exc  out  5;  rsp_err  out  1  result, flags, timeout abort.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-016 IDLE: reqN_ready high only for the granted requester; the other ready is low; both low in all other states.
REQ-017 Grant: only one valid -> that one; both valid -> requester not granted last (round-robin via last_grant register).
REQ-018 Accept = valid & ready in IDLE: latch op/a/b and id, update last_grant, go ISSUE next cycle.
REQ-019 ISSUE: fpu_start=1 for exactly one cycle with latched fpu_op/opa/opb, then WAIT.
REQ-020 fpu_op/opa/opb hold latched values from ISSUE until next accept.
REQ-021 fpu_done sampled only in WAIT; fpu_done in IDLE/ISSUE/RESP ignored.
REQ-022 WAIT & fpu_done: capture fpu_result, fpu_exc, rsp_err=0, go RESP.
REQ-023 RESP: rsp_valid=1 one cycle with rsp_id/data/exc/err; return IDLE; rsp_* data hold until next RESP.
REQ-024 Minimum accept-to-rsp_valid latency = 3 cycles (done in first WAIT cycle); new accept possible in cycle after RESP.
REQ-025 Requester deasserting valid while not ready is legal; no request is lost once accepted.
REQ-026 Operand changes after accept do not affect the in-flight operation.

Reset
REQ-027 rst_n low: state IDLE, last_grant=1 (requester 0 wins first tie), all ready/start/rsp_valid/rsp_err 0, rsp_id 0, fpu_op/opa/opb/rsp_data/rsp_exc 0, timeout counter 0.
REQ-028 Reset mid-operation aborts it immediately with no response; fpu_done after reset release ignored in IDLE.

Configuration
REQ-029 Macro FPU_REQ_TIMEOUT_EN selects watchdog.
REQ-030 Defined: counter clears on ISSUE, increments each WAIT cycle; fpu_done absent when counter reaches TIMEOUT_CYCLES -> RESP with rsp_err=1, rsp_data=0, rsp_exc=0; fpu_done on same cycle wins (normal response).
REQ-031 Not defined: no counter, WAIT waits indefinitely, rsp_err constant 0.

Verification
REQ-032 Single: req0 op=1, a=64'h3FF0000000000000, b=64'h4000000000000000; done 2 cycles after start with result 64'h4008000000000000 -> one rsp_valid, rsp_id=0, rsp_data=64'h4008000000000000, rsp_err=0.
REQ-033 Contention: both valid continuously, 4 ops -> grant order 0,1,0,1 after reset; rsp_id sequence matches.
REQ-034 Latency: done asserted in first WAIT cycle -> rsp_valid exactly 3 cycles after accept; spurious done in IDLE -> no rsp_valid.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=8): done never asserted -> rsp_valid with rsp_err=1, rsp_data=0 after 8 WAIT cycles; next request served normally.
REQ-036 Reset mid-WAIT: rst_n low 1 cycle -> no rsp_valid, both ready return high-eligible, next tie grants requester 0.

Source files
------------

// File: rtl/fpu_req_arbiter_if.sv
// Bundle of the requester, FPU-core and response signals of fpu_req_arbiter.
// slave  : the arbiter itself.
// master : the surrounding requesters / FPU core / response consumer.
interface fpu_req_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_op;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_op;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [63:0] fpu_opa;
  logic [63:0] fpu_opb;
  logic        fpu_done;
  logic [63:0] fpu_result;
  logic [4:0]  fpu_exc;
  logic        rsp_valid;
  logic        rsp_id;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_exc;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  fpu_done, fpu_result, fpu_exc,
    output req0_ready, req1_ready,
    output fpu_start, fpu_op, fpu_opa, fpu_opb,
    output rsp_valid, rsp_id, rsp_data, rsp_exc, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output fpu_done, fpu_result, fpu_exc,
    input  req0_ready, req1_ready,
    input  fpu_start, fpu_op, fpu_opa, fpu_opb,
    input  rsp_valid, rsp_id, rsp_data, rsp_exc, rsp_err
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Two-requester round-robin front end for a single FPU core, one operation
// in flight. Optional watchdog on the core: define FPU_REQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | offer ready to the granted requester, latch operation on accept
// ISSUE | one-cycle fpu_start with latched operands
// WAIT  | wait for fpu_done (or watchdog expiry when enabled)
// RESP  | one-cycle rsp_valid with captured result
module fpu_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst_n,
  fpu_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] opa_q, opa_d;
  logic [63:0] opb_q, opb_d;
  logic        rsp_id_q, rsp_id_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_exc_q, rsp_exc_d;
  logic        rsp_err_q, rsp_err_d;
  logic        idle, grant0, grant1;

`ifdef FPU_REQ_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout;

  // counter holds the number of completed WAIT cycles
  assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`endif

  // ready is also gated by rst_n so nothing looks acceptable while in reset
  assign idle   = rst_n && (state_q == IDLE);
  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);

  assign bus.req0_ready = idle && grant0;
  assign bus.req1_ready = idle && grant1;
  assign bus.fpu_start  = (state_q == ISSUE);
  assign bus.fpu_op     = op_q;
  assign bus.fpu_opa    = opa_q;
  assign bus.fpu_opb    = opb_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_exc    = rsp_exc_q;
  assign bus.rsp_err    = rsp_err_q;

  // next-state, operand latch and response capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_exc_d    = rsp_exc_q;
    rsp_err_d    = rsp_err_q;
`ifdef FPU_REQ_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (idle && (grant0 || grant1)) begin
          id_d         = grant1;
          last_grant_d = grant1;
          op_d         = grant1 ? bus.req1_op : bus.req0_op;
          opa_d        = grant1 ? bus.req1_a  : bus.req0_a;
          opb_d        = grant1 ? bus.req1_b  : bus.req0_b;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FPU_REQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
`ifdef FPU_REQ_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // a done arriving on the expiry cycle still counts as a normal result
        if (bus.fpu_done) begin
          rsp_id_d   = id_q;
          rsp_data_d = bus.fpu_result;
          rsp_exc_d  = bus.fpu_exc;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
`ifdef FPU_REQ_TIMEOUT_EN
        else if (timeout) begin
          rsp_id_d   = id_q;
          rsp_data_d = '0;
          rsp_exc_d  = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_exc_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_exc_q    <= rsp_exc_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef FPU_REQ_TIMEOUT_EN
  // watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Bench for fpu_req_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (pending op, accept/response timestamps).
module tb_fpu_req_arbiter;

`ifdef FPU_REQ_TIMEOUT_EN
  localparam int TO     = 8;
  localparam int TO_LIM = 8;
`else
  localparam int TO     = 255;
  localparam int TO_LIM = 1 << 30;
`endif
  localparam int NEVER = 2_000_000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_req_arbiter_if ifc ();

  fpu_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // model state
  int          cyc = 0;
  bit          busy = 0;
  int          last_grant = 1;
  int          t_acc = 0, td = 0, t_resp = 0;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b;
  int          in_id;
  logic [63:0] exp_res;
  logic [4:0]  exp_exc;
  bit          exp_err;
  logic [2:0]  h_op = '0;
  logic [63:0] h_opa = '0, h_opb = '0;
  logic        h_rid = 1'b0;
  logic [63:0] h_rdata = '0;
  logic [4:0]  h_rexc = '0;
  logic        h_rerr = 1'b0;

  // requester stimulus
  bit          sv [2];
  logic [2:0]  sop[2];
  logic [63:0] sa [2];
  logic [63:0] sb [2];
  int          done_delay = 1;
  bit          fixed_res_en = 0;
  bit          spurious_en = 0;

  // observations of the DUT
  int dut_grant[$];
  int dut_rsp_id[$];
  int dut_rsp_cnt = 0;
  int dut_acc_cyc = 0, dut_rsp_cyc = 0;
  logic [63:0] dut_last_data;
  logic        dut_last_err;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] core_res(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    return (a ^ {b[31:0], b[63:32]}) + 64'(op);
  endfunction

  function automatic logic [4:0] core_exc(logic [2:0] op, logic [63:0] a, logic [63:0] b);
    return a[4:0] ^ b[9:5] ^ {2'b00, op};
  endfunction

  task automatic new_payload(int k);
    sop[k] = 3'($urandom);
    sa[k]  = {$urandom, $urandom};
    sb[k]  = {$urandom, $urandom};
  endtask

  // Schedule the core's done at cycle t; derive when and what the response is.
  task automatic set_td(int t);
    td = t;
    if (td <= t_acc + 1 + TO_LIM) begin
      t_resp  = td + 1;
      exp_err = 0;
      exp_res = fixed_res_en ? 64'h4008000000000000 : core_res(in_op, in_a, in_b);
      exp_exc = core_exc(in_op, in_a, in_b);
    end else begin
      t_resp  = t_acc + 2 + TO_LIM;
      exp_err = 1;
      exp_res = '0;
      exp_exc = '0;
    end
  endtask

  task automatic run_cycle();
    logic        d;
    logic [63:0] dres;
    logic [4:0]  dexc;
    bit          er0, er1, es, ev;
    int          k;
    @(negedge clk);
    ifc.req0_valid = sv[0]; ifc.req0_op = sop[0]; ifc.req0_a = sa[0]; ifc.req0_b = sb[0];
    ifc.req1_valid = sv[1]; ifc.req1_op = sop[1]; ifc.req1_a = sa[1]; ifc.req1_b = sb[1];
    d    = 1'b0;
    dres = {$urandom, $urandom};
    dexc = 5'($urandom);
    if (busy && cyc == td) begin
      d    = 1'b1;
      dres = fixed_res_en ? 64'h4008000000000000 : core_res(in_op, in_a, in_b);
      dexc = core_exc(in_op, in_a, in_b);
    end else if (spurious_en && (!busy || cyc == t_acc + 1 || cyc == t_resp) &&
                 $urandom_range(0, 2) == 0) begin
      d = 1'b1;
    end
    ifc.fpu_done = d; ifc.fpu_result = dres; ifc.fpu_exc = dexc;
    #1;
    if (ifc.req0_valid && ifc.req0_ready) begin dut_grant.push_back(0); dut_acc_cyc = cyc; end
    if (ifc.req1_valid && ifc.req1_ready) begin dut_grant.push_back(1); dut_acc_cyc = cyc; end
    if (ifc.rsp_valid) begin
      dut_rsp_cnt++;
      dut_rsp_id.push_back(int'(ifc.rsp_id));
      dut_rsp_cyc   = cyc;
      dut_last_data = ifc.rsp_data;
      dut_last_err  = ifc.rsp_err;
    end

    er0 = !busy && sv[0] && (!sv[1] || last_grant == 1);
    er1 = !busy && sv[1] && (!sv[0] || last_grant == 0);
    chk("req0_ready", ifc.req0_ready, er0);
    chk("req1_ready", ifc.req1_ready, er1);

    es = busy && cyc == t_acc + 1;
    chk("fpu_start", ifc.fpu_start, es);
    if (es) begin h_op = in_op; h_opa = in_a; h_opb = in_b; end
    chk("fpu_op", ifc.fpu_op, h_op);
    chk("fpu_opa", ifc.fpu_opa, h_opa);
    chk("fpu_opb", ifc.fpu_opb, h_opb);

    ev = busy && cyc == t_resp;
    chk("rsp_valid", ifc.rsp_valid, ev);
    if (ev) begin
      h_rid = 1'(in_id); h_rdata = exp_res; h_rexc = exp_exc; h_rerr = exp_err;
      busy = 0;
    end
    chk("rsp_id", ifc.rsp_id, h_rid);
    chk("rsp_data", ifc.rsp_data, h_rdata);
    chk("rsp_exc", ifc.rsp_exc, h_rexc);
    chk("rsp_err", ifc.rsp_err, h_rerr);

    if (er0 || er1) begin
      k = er1 ? 1 : 0;
      busy = 1; t_acc = cyc;
      in_op = sop[k]; in_a = sa[k]; in_b = sb[k]; in_id = k;
      last_grant = k;
      sv[k] = 0;
      set_td(done_delay < 0 ? NEVER : cyc + 1 + done_delay);
    end
    cyc++;
  endtask

  task automatic run_until_idle(int max);
    int n = 0;
    while (busy && n < max) begin
      run_cycle();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.fpu_done = 1'b0;
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    #1;
    chk("rst_ready0", ifc.req0_ready, 1'b0);
    chk("rst_ready1", ifc.req1_ready, 1'b0);
    chk("rst_start", ifc.fpu_start, 1'b0);
    chk("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    chk("rst_rsp_err", ifc.rsp_err, 1'b0);
    chk("rst_rsp_id", ifc.rsp_id, 1'b0);
    chk("rst_fpu_op", ifc.fpu_op, 3'd0);
    chk("rst_fpu_opa", ifc.fpu_opa, 64'd0);
    chk("rst_rsp_data", ifc.rsp_data, 64'd0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    sv[0] = 0; sv[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0; last_grant = 1;
    h_op = '0; h_opa = '0; h_opb = '0;
    h_rid = 1'b0; h_rdata = '0; h_rexc = '0; h_rerr = 1'b0;
  endtask

  initial begin
    int n0;
    ifc.req0_valid = 1'b0; ifc.req0_op = '0; ifc.req0_a = '0; ifc.req0_b = '0;
    ifc.req1_valid = 1'b0; ifc.req1_op = '0; ifc.req1_a = '0; ifc.req1_b = '0;
    ifc.fpu_done = 1'b0; ifc.fpu_result = '0; ifc.fpu_exc = '0;
    sv[0] = 0; sv[1] = 0;
    new_payload(0); new_payload(1);
    repeat (2) @(negedge clk);
    do_reset();

    // single operation with a known core result
    fixed_res_en = 1; done_delay = 2;
    sv[0] = 1; sop[0] = 3'd1;
    sa[0] = 64'h3FF0000000000000; sb[0] = 64'h4000000000000000;
    run_cycle();
    run_until_idle(20);
    run_cycle();
    chk("single_rsp_count", dut_rsp_cnt, 1);
    chk("single_rsp_id", dut_rsp_id.size() > 0 ? dut_rsp_id[0] : 99, 0);
    chk("single_rsp_data", dut_last_data, 64'h4008000000000000);
    chk("single_rsp_err", dut_last_err, 1'b0);
    fixed_res_en = 0;

    // minimum latency, then spurious done while idle
    done_delay = 1;
    new_payload(1); sv[1] = 1;
    run_cycle();
    run_until_idle(20);
    chk("min_latency", dut_rsp_cyc - dut_acc_cyc, 3);
    spurious_en = 1;
    n0 = dut_rsp_cnt;
    repeat (10) run_cycle();
    chk("spurious_no_rsp", dut_rsp_cnt, n0);

    // contention from reset: alternate grants
    do_reset();
    dut_grant.delete(); dut_rsp_id.delete();
    begin
      int guard = 0;
      while (dut_grant.size() < 4 && guard < 80) begin
        for (int k = 0; k < 2; k++) if (!sv[k]) begin new_payload(k); sv[k] = 1; end
        done_delay = $urandom_range(1, 3);
        run_cycle();
        guard++;
      end
    end
    sv[0] = 0; sv[1] = 0;
    run_until_idle(20);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), i < dut_grant.size() ? dut_grant[i] : 99, i % 2);
      chk($sformatf("rr_rsp_id%0d", i), i < dut_rsp_id.size() ? dut_rsp_id[i] : 99, i % 2);
    end

`ifdef FPU_REQ_TIMEOUT_EN
    // watchdog abort, then a normal request
    done_delay = -1;
    new_payload(0); sv[0] = 1;
    run_cycle();
    run_until_idle(40);
    chk("to_latency", dut_rsp_cyc - dut_acc_cyc, 10);
    chk("to_err", dut_last_err, 1'b1);
    chk("to_data", dut_last_data, 64'd0);
    done_delay = 2;
    new_payload(1); sv[1] = 1;
    run_cycle();
    run_until_idle(20);
    chk("after_to_err", dut_last_err, 1'b0);
`else
    // without the watchdog the arbiter waits as long as it takes
    done_delay = -1;
    new_payload(0); sv[0] = 1;
    run_cycle();
    n0 = dut_rsp_cnt;
    repeat (300) run_cycle();
    chk("no_to_still_waiting", dut_rsp_cnt, n0);
    set_td(cyc);
    run_until_idle(20);
    chk("late_done_rsp", dut_rsp_cnt, n0 + 1);
    chk("late_done_err", dut_last_err, 1'b0);
`endif

    // reset in the middle of WAIT aborts silently
    done_delay = -1;
    new_payload(1); sv[1] = 1;
    run_cycle();
    repeat (3) run_cycle();
    n0 = dut_rsp_cnt;
    do_reset();
    done_delay = 1;
    repeat (6) run_cycle();
    chk("rst_abort_no_rsp", dut_rsp_cnt, n0);
    dut_grant.delete();
    new_payload(0); new_payload(1); sv[0] = 1; sv[1] = 1;
    run_cycle();
    chk("rst_tie_grant", dut_grant.size() > 0 ? dut_grant[0] : 99, 0);
    run_until_idle(20);
    run_cycle();
    run_until_idle(20);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (sv[k] && $urandom_range(0, 9) == 0) sv[k] = 0;
        else if (!sv[k] && $urandom_range(0, 1) == 1) begin new_payload(k); sv[k] = 1; end
      end
      done_delay = $urandom_range(1, 4);
      run_cycle();
    end
    sv[0] = 0; sv[1] = 0;
    run_until_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
